// File: rtl/line_window_buffer.sv
// Multi-line pixel buffer: emits each accepted pixel with the NUM_LINES pixels above it
// (one vertical window column per cycle) plus column/row position and end-of-line/frame marks.
module line_window_buffer #(
  parameter  int DATA_W    = 8,
  parameter  int LINE_W    = 640,
  parameter  int NUM_LINES = 2,
  parameter  int MAX_ROWS  = 480,
  localparam int COL_W     = (LINE_W > 1) ? $clog2(LINE_W) : 1,
  localparam int ROW_W     = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1,
  localparam int WIN_W     = (NUM_LINES + 1) * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              sof_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [WIN_W-1:0]  data_o,
  output logic [COL_W-1:0]  col_o,
  output logic [ROW_W-1:0]  row_o,
  output logic              eol_o,
  output logic              eof_o
);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE_W - 1);
  localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(MAX_ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_PRIME = ROW_W'(NUM_LINES);

  logic [DATA_W-1:0] line_mem [NUM_LINES][LINE_W];
  logic [DATA_W-1:0] rd_data  [NUM_LINES];

  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row, row_inc;
  logic             primed_q, primed_d, cur_primed;
  logic             col_last, row_last, out_vld;
  logic [WIN_W-1:0] win_d;

  logic             valid_q, eol_q, eof_q;
  logic [WIN_W-1:0] data_q;
  logic [COL_W-1:0] col_out_q;
  logic [ROW_W-1:0] row_out_q;

  // A start-of-frame pixel is treated as (0,0) of an unprimed frame in the same cycle.
  always_comb begin
    cur_col    = sof_i ? '0 : col_q;
    cur_row    = sof_i ? '0 : row_q;
    cur_primed = sof_i ? 1'b0 : primed_q;
    col_last   = (cur_col == COL_LAST);
    row_last   = (cur_row == ROW_LAST);
    row_inc    = cur_row + ROW_ONE;
    out_vld    = valid_i && cur_primed;
  end

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    primed_d = primed_q;
    if (valid_i) begin
      col_d    = col_last ? '0 : cur_col + COL_ONE;
      row_d    = cur_row;
      primed_d = cur_primed;
      if (col_last) begin
        row_d    = row_last ? '0 : row_inc;
        primed_d = row_last ? 1'b0 : (cur_primed || (row_inc == ROW_PRIME));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      primed_q <= primed_d;
    end
  end

  // Read-before-write: the old column contents feed both the window and the line shift.
  always_comb begin
    for (int k = 0; k < NUM_LINES; k++) begin
      rd_data[k] = line_mem[k][cur_col];
    end
  end

  always_comb begin
    win_d = '0;
    win_d[DATA_W-1:0] = data_i;
    for (int k = 0; k < NUM_LINES; k++) begin
      win_d[(k+1)*DATA_W +: DATA_W] = rd_data[k];
    end
  end

  always_ff @(posedge clk) begin
    if (valid_i) begin
      line_mem[0][cur_col] <= data_i;
      for (int k = 1; k < NUM_LINES; k++) begin
        line_mem[k][cur_col] <= rd_data[k-1];
      end
    end
  end

  // Output register stage; window/position hold their last value across input gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      data_q    <= '0;
      col_out_q <= '0;
      row_out_q <= '0;
    end else begin
      valid_q <= out_vld;
      eol_q   <= out_vld && col_last;
      eof_q   <= out_vld && col_last && row_last;
      if (valid_i) begin
        data_q    <= win_d;
        col_out_q <= cur_col;
        row_out_q <= cur_row;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign col_o   = col_out_q;
  assign row_o   = row_out_q;
  assign eol_o   = eol_q;
  assign eof_o   = eof_q;

endmodule
